multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and write-back per opcode.
//  Drives the datapath muxes and enables, and drives alu_op into the ALU-control decoder.
//  Waits on the memory ready handshake, with a bounded timeout.
// PARAMETERS
//  MEM_TIMEOUT  8  max cycles waited for mem_ready in a memory state (>=1); reaching it aborts to FETCH
//  CNT_W        4  width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk            in   1  single clock, rising edge
//  rst_n          in   1  synchronous, active-low reset
//  opcode         in   6  instr[31:26] from instruction register
//  mem_ready      in   1  memory completes the current access this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  pc_source      out  2  00 ALU result, 01 ALUOut, 10 jump target
//  iord           out  1  memory address: 0 PC, 1 ALUOut
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe
//  ir_write       out  1  instruction register load
//  mem_to_reg     out  1  RF write data: 0 ALUOut, 1 MDR
//  reg_dst        out  1  RF write address: 0 rt, 1 rd
//  reg_write      out  1  RF write enable
//  alu_src_a      out  1  0 PC, 1 A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  2  00 add, 01 sub, 10 use funct
//  illegal_op     out  1  one-cycle pulse: unsupported opcode decoded
//  mem_err        out  1  one-cycle pulse: memory timeout abort
//  state          out  4  current state (debug)
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-low: rst_n=0 at posedge -> state=FETCH, wait_cnt=0, pulses cleared.
//  - While rst_n=0, all control outputs are forced to 0 combinationally.
//  - State encoding: FETCH0 DECODE1 MEM_ADDR2 MEM_RD3 MEM_WB4 MEM_WR5 EXEC6 R_WB7 BRANCH8 JUMP9 ADDI_EX10 ADDI_WB11.
//  - Moore outputs decoded from the registered state; any output not listed is 0.
//  - FETCH: mem_read, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stays until mem_ready, then ->DECODE.
//  - DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut).
//    Next state by opcode: 00->EXEC; 23,2B->MEM_ADDR; 04->BRANCH; 02->JUMP; 08->ADDI_EX (macro only); else ->FETCH with illegal_op.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. 23->MEM_RD, 2B->MEM_WR.
//  - MEM_RD: mem_read, iord=1. mem_ready -> MEM_WB. MEM_WB: reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - MEM_WR: mem_write, iord=1. mem_ready -> FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write, reg_dst=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01 -> FETCH.
//  - JUMP: pc_write, pc_source=10 -> FETCH.
//  - Cycle counts with mem_ready=1 on first request cycle: R 4, lw 5, sw 4, beq 3, j 3, addi 4.
//  - Memory wait (FETCH, MEM_RD, MEM_WR):
//    - wait_cnt clears on entering a memory state; increments each cycle mem_ready=0.
//    - mem_ready=0 with wait_cnt==MEM_TIMEOUT-1 -> next state FETCH, mem_err pulses 1 cycle, no ir/pc/reg update.
//    - mem_ready=1 in the same cycle the limit is reached: completes normally; ready wins.
//  - illegal_op and mem_err are registered: asserted the cycle after the triggering state, cleared the cycle after.
//  - Reset mid-instruction: the FSM abandons the instruction at that edge and starts at FETCH; no partial write.
//  - Unused encodings 12-15 -> FETCH next cycle, all outputs 0.
// CONFIGURATION
//  - MULTICYCLE_ADDI_EN defined: opcode 08 in DECODE -> ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00) -> ADDI_WB.
//    ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - MULTICYCLE_ADDI_EN undefined: opcode 08 is illegal (illegal_op pulse, ->FETCH); states 10/11 are unreachable.
// TESTING
//  - rst_n=0 2 cycles with opcode=23, mem_ready=1: all outputs 0 while low; after release state=0, mem_read=1.
//  - R-type (opcode 00), mem_ready=1 -> states 0,1,6,7,0. alu_op=10 in state 6; reg_write=1, reg_dst=1 in state 7.
//  - lw (23), mem_ready=0 two cycles in MEM_RD then 1 -> states 0,1,2,3,3,3,4,0. mem_to_reg=1 in 4.
//  - beq (04) -> states 0,1,8,0 with alu_op=01, pc_write_cond=1, pc_source=01 in 8.
//    j (02) -> pc_write=1, pc_source=10.
//  - FETCH with mem_ready held 0, MEM_TIMEOUT=8 -> 8 cycles in state 0, mem_err pulse, ir_write never 1.
//    Also mem_ready=1 on the 8th cycle -> normal DECODE, no mem_err.
//  - opcode 08 with macro -> states 0,1,10,11,0, reg_write=1 in 11. Without macro -> 0,1,0 with illegal_op pulse.
//    opcode 3F -> illegal_op in both builds.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS datapath with a bounded memory-ready wait.
// Optional ADDI support is enabled by defining MULTICYCLE_ADDI_EN.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11
    } state_e;

    localparam logic [5:0] OpR   = 6'h00;
    localparam logic [5:0] OpJ   = 6'h02;
    localparam logic [5:0] OpBeq = 6'h04;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpSw  = 6'h2B;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OpAddi = 6'h08;
`endif

    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic             mem_state;
    logic             timeout_hit;
    logic             abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Ready wins over the timeout when both land in the same cycle.
    assign timeout_hit = !mem_ready && (wait_cnt_q == WaitLast);

    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        mem_state = 1'b0;
        abort     = 1'b0;
        case (state_q)
            StFetch: begin
                mem_state = 1'b1;
                if (mem_ready)        state_d = StDecode;
                else if (timeout_hit) abort   = 1'b1;
                else                  state_d = StFetch;
            end
            StDecode: begin
                case (opcode)
                    OpR:        state_d = StExec;
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
`ifdef MULTICYCLE_ADDI_EN
                    OpAddi:     state_d = StAddiEx;
`endif
                    default:    illegal_d = 1'b1;
                endcase
            end
            StMemAddr: begin
                if (opcode == OpSw)      state_d = StMemWr;
                else if (opcode == OpLw) state_d = StMemRd;
            end
            StMemRd: begin
                mem_state = 1'b1;
                if (mem_ready)        state_d = StMemWb;
                else if (timeout_hit) abort   = 1'b1;
                else                  state_d = StMemRd;
            end
            StMemWr: begin
                mem_state = 1'b1;
                if (mem_ready)        state_d = StFetch;
                else if (timeout_hit) abort   = 1'b1;
                else                  state_d = StMemWr;
            end
            StExec:   state_d = StRWb;
`ifdef MULTICYCLE_ADDI_EN
            StAddiEx: state_d = StAddiWb;
`endif
            default:  state_d = StFetch;
        endcase
        mem_err_d = abort;
        // Counter restarts on any entry (including re-entry of FETCH after an abort).
        if (mem_state && !abort && (state_d == state_q)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
        else                                             wait_cnt_d = '0;
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        mem_err       = 1'b0;
        state         = 4'd0;
        if (rst_n) begin
            illegal_op = illegal_q;
            mem_err    = mem_err_q;
            state      = state_q;
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: alu_src_b = 2'b11;
                StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                StRWb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                StJump: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
`ifdef MULTICYCLE_ADDI_EN
                StAddiEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StAddiWb: reg_write = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level model builds the expected
// per-cycle trace; a negedge process compares it against the DUT.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_err;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc;
    bit pend_ill = 1'b0;
    bit pend_err = 1'b0;
    logic [21:0] exp_q[$];
    logic [21:0] act;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  illegal_op, mem_err};

    // Control word the datapath needs in a given step, straight from the state table.
    function automatic logic [21:0] exp_word(int st, bit rdy, bit ill, bit err);
        logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] ps, asb, aop;
        logic [3:0] s4;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa} = '0;
        {ps, asb, aop} = '0;
        s4 = st[3:0];
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {s4, pw, pwc, ps, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill, err};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [21:0] w;
            w = exp_q.pop_front();
            n_checks++;
            if (act !== w) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act, w);
            end
        end
    end

    task automatic cyc(int st, bit rdy);
        exp_q.push_back(exp_word(st, rdy, pend_ill, pend_err));
        pend_ill  = 1'b0;
        pend_err  = 1'b0;
        mem_ready = rdy;
        @(posedge clk); #1;
        ncyc++;
    endtask

    task automatic cyc_rst();
        exp_q.push_back(22'h0);
        pend_ill  = 1'b0;
        pend_err  = 1'b0;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // A memory access that sees `waits` not-ready cycles before ready.
    task automatic mem_phase(int st, int waits, output bit aborted);
        for (int i = 0; i < waits && i < MEM_TIMEOUT; i++) cyc(st, 1'b0);
        if (waits >= MEM_TIMEOUT) begin
            aborted  = 1'b1;
            pend_err = 1'b1;
        end else begin
            cyc(st, 1'b1);
            aborted = 1'b0;
        end
    endtask

    task automatic do_instr(logic [5:0] op, int wf, int wm, int exp_len, string name);
        bit ab;
        opcode = op;
        ncyc   = 0;
        mem_phase(0, wf, ab);
        if (!ab) begin
            cyc(1, 1'b1);
            case (op)
                6'h00: begin cyc(6, 1'b1); cyc(7, 1'b1); end
                6'h23: begin cyc(2, 1'b1); mem_phase(3, wm, ab); if (!ab) cyc(4, 1'b1); end
                6'h2B: begin cyc(2, 1'b1); mem_phase(5, wm, ab); end
                6'h04: cyc(8, 1'b1);
                6'h02: cyc(9, 1'b1);
`ifdef MULTICYCLE_ADDI_EN
                6'h08: begin cyc(10, 1'b1); cyc(11, 1'b1); end
`endif
                default: pend_ill = 1'b1;
            endcase
        end
        n_checks++;
        if (ncyc != exp_len) begin
            n_fail++;
            $display("FAIL len_%s got=%0d expected=%0d", name, ncyc, exp_len);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'h23;
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (act !== 22'h0) begin
                n_fail++;
                $display("FAIL reset_outputs got=%h expected=0", act);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (state !== 4'd0 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset got state=%0d mem_read=%b expected 0/1", state, mem_read);
        end

        do_instr(6'h23, 0, 0, 5, "lw");
        do_instr(6'h00, 0, 0, 4, "rtype");
        do_instr(6'h23, 0, 2, 7, "lw_wait2");
        do_instr(6'h2B, 0, 0, 4, "sw");
        do_instr(6'h04, 0, 0, 3, "beq");
        do_instr(6'h02, 0, 0, 3, "j");
        do_instr(6'h00, 8, 0, 8, "fetch_timeout");
        do_instr(6'h00, 7, 0, 11, "fetch_ready_last");
        do_instr(6'h23, 0, 8, 11, "lw_timeout");
        do_instr(6'h2B, 0, 3, 7, "sw_wait3");
`ifdef MULTICYCLE_ADDI_EN
        do_instr(6'h08, 0, 0, 4, "addi");
`else
        do_instr(6'h08, 0, 0, 2, "addi_illegal");
`endif
        do_instr(6'h3F, 0, 0, 2, "op3f");
        do_instr(6'h04, 0, 0, 3, "beq2");

        // Reset while waiting in MEM_RD: no write-back, restart at FETCH.
        opcode = 6'h23;
        cyc(0, 1'b1);
        cyc(1, 1'b1);
        cyc(2, 1'b1);
        cyc(3, 1'b0);
        cyc_rst();
        do_instr(6'h00, 0, 0, 4, "rtype_after_reset");
        do_instr(6'h3F, 0, 0, 2, "op3f_2");
        cyc(0, 1'b0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
